// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Format modes, field widths and shift amounts per mode.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        SIMM13 = 2'd0,
        DISP22 = 2'd1,
        DISP30 = 2'd2,
        IMM22  = 2'd3
    } imm_mode_e;

    localparam int SIMM13_W = 13;
    localparam int DISP22_W = 22;
    localparam int DISP30_W = 30;
    localparam int IMM22_W  = 22;

    localparam int SIMM13_SH = 0;
    localparam int DISP22_SH = 2;
    localparam int DISP30_SH = 2;
    localparam int IMM22_SH  = 10;

    localparam int FIELD_MAX_W = 30;

    function automatic int field_w(input imm_mode_e m);
        int w;
        w = SIMM13_W;
        unique case (m)
            SIMM13: w = SIMM13_W;
            DISP22: w = DISP22_W;
            DISP30: w = DISP30_W;
            IMM22:  w = IMM22_W;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// Generic valid/ready register slice with asynchronous active-high reset.
// Loads whenever it is empty or its contents drain in the same cycle.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v_q;
    logic         v_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         load;

    assign in_ready  = !v_q || out_ready;
    assign load      = in_valid && in_ready;
    assign out_valid = v_q;
    assign out_data  = data_q;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (load) begin
            v_d    = 1'b1;
            data_d = in_data;
        end else if (out_ready) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator: S1 captures the field, S2 extends/shifts.
// Define IMM_EXT_ERRCHK_EN to flag non-zero input bits above the field.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 30,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam int XW   = OUT_W + 2;
    localparam int S1_W = FIELD_MAX_W + 2 + 1;
    localparam int S2_W = OUT_W + 1;

    imm_mode_e                in_mode_e;
    logic [FIELD_MAX_W-1:0]   s1_field_d;
    logic                     s1_err_d;
    logic [S1_W-1:0]          s1_in;

    logic                     s1_valid;
    logic                     s1_ready;
    logic [S1_W-1:0]          s1_out;

    logic [FIELD_MAX_W-1:0]   s1_field_q;
    imm_mode_e                s1_mode_q;
    logic                     s1_err_q;

    logic [XW-1:0]            ext;
    logic [OUT_W-1:0]         s2_res_d;
    logic [S2_W-1:0]          s2_in;
    logic [S2_W-1:0]          s2_out;
    logic                     s2_valid;
    logic                     s2_err_q;
    logic                     unused_hi;

    assign in_mode_e = imm_mode_e'(in_mode);

    // Only the mode's field bits travel; anything above is dropped here.
    always_comb begin
        s1_field_d = '0;
        unique case (in_mode_e)
            SIMM13: s1_field_d[SIMM13_W-1:0] = in_imm[SIMM13_W-1:0];
            DISP22: s1_field_d[DISP22_W-1:0] = in_imm[DISP22_W-1:0];
            DISP30: s1_field_d[DISP30_W-1:0] = in_imm[DISP30_W-1:0];
            IMM22:  s1_field_d[IMM22_W-1:0]  = in_imm[IMM22_W-1:0];
        endcase
    end

`ifdef IMM_EXT_ERRCHK_EN
    always_comb begin
        s1_err_d = |(in_imm >> field_w(in_mode_e));
    end
`else
    assign s1_err_d = 1'b0;
`endif

    assign s1_in = {s1_err_d, in_mode, s1_field_d};

    pipe_slice #(
        .W(S1_W)
    ) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_out)
    );

    assign s1_field_q = s1_out[FIELD_MAX_W-1:0];
    assign s1_mode_q  = imm_mode_e'(s1_out[FIELD_MAX_W+1:FIELD_MAX_W]);
    assign s1_err_q   = s1_out[S1_W-1];

    always_comb begin
        ext = '0;
        unique case (s1_mode_q)
            SIMM13: begin
                ext = {{(XW-SIMM13_W){s1_field_q[SIMM13_W-1]}},
                       s1_field_q[SIMM13_W-1:0]};
                ext = ext << SIMM13_SH;
            end
            DISP22: begin
                ext = {{(XW-DISP22_W){s1_field_q[DISP22_W-1]}},
                       s1_field_q[DISP22_W-1:0]};
                ext = ext << DISP22_SH;
            end
            DISP30: begin
                ext = {{(XW-DISP30_W){s1_field_q[DISP30_W-1]}},
                       s1_field_q[DISP30_W-1:0]};
                ext = ext << DISP30_SH;
            end
            IMM22: begin
                ext = {{(XW-IMM22_W){1'b0}},
                       s1_field_q[IMM22_W-1:0]};
                ext = ext << IMM22_SH;
            end
        endcase
    end

    // Bits beyond OUT_W are intentionally discarded without a flag.
    assign s2_res_d  = ext[OUT_W-1:0];
    assign unused_hi = ^ext[XW-1:OUT_W];
    assign s2_in     = {s1_err_q, s2_res_d};

    pipe_slice #(
        .W(S2_W)
    ) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign s2_err_q  = s2_out[S2_W-1];
    assign out_valid = s2_valid;
    assign out_data  = s2_out[OUT_W-1:0];
    assign out_err   = s2_valid && s2_err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (IN_W=30, OUT_W=32).
// Expected values are hand-computed constants.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int passed;
    int total;

`ifdef IMM_EXT_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    imm_extend_pipe #(
        .IN_W  (30),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m,
                         input logic [29:0] imm);
        in_valid = v;
        in_mode  = m;
        in_imm   = imm;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d,
                           input logic e);
        chk({tag, "_v"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_d"}, {32'd0, out_data}, {32'd0, d});
        chk({tag, "_e"}, {63'd0, out_err}, {63'd0, e});
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_err", {63'd0, out_err}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Latency: presented in cycle 0, visible in cycle 2.
        drive(1'b1, 2'd0, 30'h1001);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        chk("lat_c1_v", {63'd0, out_valid}, 64'd0);
        tick();
        chk_out("simm13_neg", 32'hFFFFF001, 1'b0);
        tick();
        chk("lat_c3_v", {63'd0, out_valid}, 64'd0);

        drive(1'b1, 2'd0, 30'h0EE3);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        tick();
        chk_out("simm13_pos", 32'h00000EE3, 1'b0);
        tick();

        drive(1'b1, 2'd1, 30'h200000);
        tick();
        drive(1'b1, 2'd2, 30'h3FFFFFFF);
        tick();
        drive(1'b1, 2'd3, 30'h3FFFFF);
        chk_out("disp22", 32'hFF800000, 1'b0);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        chk_out("disp30", 32'hFFFFFFFC, 1'b0);
        tick();
        chk_out("imm22", 32'hFFFFFC00, 1'b0);
        tick();
        chk("b2b_idle", {63'd0, out_valid}, 64'd0);

        // Four back-to-back beats with the consumer always ready.
        drive(1'b1, 2'd1, 30'h1);
        chk("b2b_rdy0", {63'd0, in_ready}, 64'd1);
        tick();
        drive(1'b1, 2'd0, 30'h1FFF);
        chk("b2b_rdy1", {63'd0, in_ready}, 64'd1);
        tick();
        drive(1'b1, 2'd3, 30'h1);
        chk("b2b_rdy2", {63'd0, in_ready}, 64'd1);
        chk_out("b2b_0", 32'h00000004, 1'b0);
        tick();
        drive(1'b1, 2'd2, 30'h10000000);
        chk("b2b_rdy3", {63'd0, in_ready}, 64'd1);
        chk_out("b2b_1", 32'hFFFFFFFF, 1'b0);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        chk_out("b2b_2", 32'h00000400, 1'b0);
        tick();
        chk_out("b2b_3", 32'h40000000, 1'b0);
        tick();
        chk("b2b_end", {63'd0, out_valid}, 64'd0);

        // Backpressure: two beats buffered, third waits for release.
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 30'h0123);
        tick();
        drive(1'b1, 2'd1, 30'h3FFFFF);
        chk("bp_rdy1", {63'd0, in_ready}, 64'd1);
        tick();
        drive(1'b1, 2'd3, 30'h000ABC);
        for (int c = 2; c < 5; c++) begin
            chk("bp_full_rdy", {63'd0, in_ready}, 64'd0);
            chk_out("bp_hold", 32'h00000123, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {63'd0, in_ready}, 64'd1);
        chk_out("bp_out1", 32'h00000123, 1'b0);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        chk_out("bp_out2", 32'hFFFFFFFC, 1'b0);
        tick();
        chk_out("bp_out3", 32'h002AF000, 1'b0);
        tick();
        chk("bp_end", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 30'h0005);
        tick();
        drive(1'b1, 2'd0, 30'h0006);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        chk("rf_full_v", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rf_async_v", {63'd0, out_valid}, 64'd0);
        chk("rf_async_rdy", {63'd0, in_ready}, 64'd1);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        drive(1'b1, 2'd0, 30'h0777);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        chk("rf_c1_v", {63'd0, out_valid}, 64'd0);
        tick();
        chk_out("rf_beat", 32'h00000777, 1'b0);
        tick();
        chk("rf_alone", {63'd0, out_valid}, 64'd0);

        // Unused-bit check on SIMM13.
        drive(1'b1, 2'd0, 30'h2000);
        tick();
        drive(1'b0, 2'd0, 30'h0);
        tick();
        chk_out("errchk", 32'h00000000, ERR_EXP);
        tick();
        chk("errchk_q", {63'd0, out_err}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate generator for the decode stage. It is the successor to the fixed 13-to-32 sign extender. It accepts a raw instruction immediate field plus a format mode and produces an OUT_W-bit operand: sign-extended, zero-filled and/or shifted per format. It sits between instruction decode and the ALU/branch-target operand muxes, behind a two-stage valid/ready pipeline so it can absorb downstream stalls.

## Interface
- IN_W, 30, width of raw immediate input; must be ≥ 30
- OUT_W, 32, width of produced operand; must be ≥ 32
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept input this cycle
- in_imm  in  IN_W  raw immediate, field right-aligned at bit 0
- in_mode  in  2  format: 0 SIMM13, 1 DISP22, 2 DISP30, 3 IMM22
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  formatted operand
- out_err  out  1  unused input bits non-zero (checker only, see Configuration)

One clock; reset is asynchronous and active-high.

## Operation
- Formats (F = field width):
  - SIMM13: F=13, sign-extend in_imm[12:0], no shift.
  - DISP22: F=22, sign-extend in_imm[21:0], then shift left 2.
  - DISP30: F=30, sign-extend in_imm[29:0], then shift left 2.
  - IMM22: F=22, zero-extend in_imm[21:0], then shift left 10; low 10 bits zero.
- Arithmetic is done in OUT_W+2 bits. Results are truncated to OUT_W; discarded high bits are not flagged.
- Stage 1 (S1) registers in_imm field bits [F-1:0], the mode, and the unused-bit check.
- Stage 2 (S2) registers the extended/shifted result and err.
- Each stage has its own valid bit. A stage loads when its downstream is empty or draining this cycle.
  - in_ready = !s1_v | !s2_v | out_ready.
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Bits of in_imm above F are ignored for the data result.

## Timing
- Reset values: out_valid=0, out_data=0, out_err=0, all stage valids 0. in_ready=1 during and after reset.
- Latency: input accepted at edge N → out_valid=1 after edge N+2 (visible in cycle N+2).
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, S2 holds and S1 can still fill. At most 2 beats are buffered.
  - in_ready falls combinationally once both stages are full and out_ready=0.
- out_data/out_err are stable while out_valid=1 and out_ready=0.
- Simultaneous pop and push with both stages full: both shift in the same cycle, no bubble.
- Reset mid-operation clears both valids immediately (asynchronous); in-flight beats are discarded.
- out_valid never depends combinationally on in_valid.

## Configuration
- IMM_EXT_ERRCHK_EN defined:
  - S1 computes err = |in_imm[IN_W-1:F] for the current mode.
  - err is carried with the beat; out_err is qualified by out_valid.
- Macro undefined: no check logic; out_err is tied to 0.
- In both cases the port list is identical.

## Structure
- imm_ext_pkg holds:
  - the mode enum (SIMM13=0, DISP22=1, DISP30=2, IMM22=3);
  - the field widths 13/22/30;
  - the shift amounts 0/2/2/10.
- Sub-module pipe_slice: a generic parametrised-width valid/ready register slice with async active-high reset. It is instantiated twice (S1, S2); all format logic stays in the top.

## Test plan
- OUT_W=32, SIMM13, in_imm=13'h1001 → out_data=32'hFFFFF001; in_imm=13'h0EE3 → 32'h00000EE3, each 2 cycles after acceptance.
- DISP22 with 22'h200000 → 32'hFF800000; DISP30 with 30'h3FFFFFFF → 32'hFFFFFFFC; IMM22 with 22'h3FFFFF → 32'hFFFFFC00.
- Back-to-back 4 beats with out_ready=1 → 4 consecutive out_valid cycles in order, in_ready stays 1.
- out_ready=0 for 5 cycles while pushing 3 beats:
  - in_ready=0 after 2 accepted;
  - out_data holds beat 1;
  - on release, beats 1, 2, 3 emerge in order.
- rst pulsed with 2 beats in flight → out_valid=0 immediately; next accepted beat appears alone 2 cycles later.
- With IMM_EXT_ERRCHK_EN, SIMM13 and in_imm bit 13 set → out_err=1 with data 32'h00000000 for in_imm=30'h2000. Without the macro, the same stimulus gives out_err=0.
